// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in, parallel-out front end.
// Collects WIDTH serial bits (gated by serial_valid) into a word and presents
// it on dataout with an out_valid/out_ready handshake. A holding register
// lets one finished word wait while the next frame shifts in; a word that
// completes while the previous one is still unconsumed is dropped and
// reported with a one-cycle overrun pulse.
// Optional build macro SIPO_PARITY_EN: each frame carries one trailing
// even-parity bit, and parity_err flags the word held in dataout.
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             serial_in,
  input  logic             serial_valid,
  output logic [WIDTH-1:0] dataout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic             load_ok;

  // The shift register moves towards the MSB when the first bit belongs in
  // dataout[WIDTH-1], and towards the LSB otherwise.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_in
          assign shift_next[gi] = serial_in;
        end else begin : g_mv
          assign shift_next[gi] = shift_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_in
          assign shift_next[gi] = serial_in;
        end else begin : g_mv
          assign shift_next[gi] = shift_reg[gi+1];
        end
      end
    end
  endgenerate

  // A finished word may be loaded if the holding register is empty or is
  // being emptied at this very edge.
  assign load_ok = !out_valid || out_ready;

  assign busy = (state_reg != IDLE);

`ifndef SIPO_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Frame FSM, holding register and handshake in one registered block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      shift_reg  <= '0;
      dataout    <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      overrun <= 1'b0;

      // Consumer takes the held word; a completing frame below may reload it.
      if (out_valid && out_ready) begin
        out_valid  <= 1'b0;
`ifdef SIPO_PARITY_EN
        parity_err <= 1'b0;
`endif
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= SHIFT;
            cnt_reg   <= '0;
            shift_reg <= '0;
          end
        end

        SHIFT: begin
          if (start) begin
            // Restart wins over any bit sampled in the same cycle.
            cnt_reg   <= '0;
            shift_reg <= '0;
          end else if (serial_valid) begin
            shift_reg <= shift_next;
            if (cnt_reg == CW'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
              state_reg <= PARITY;
              cnt_reg   <= CW'(WIDTH);
`else
              state_reg <= IDLE;
              cnt_reg   <= '0;
              if (load_ok) begin
                dataout   <= shift_next;
                out_valid <= 1'b1;
              end else begin
                overrun   <= 1'b1;
              end
`endif
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
        end

`ifdef SIPO_PARITY_EN
        PARITY: begin
          if (start) begin
            state_reg <= SHIFT;
            cnt_reg   <= '0;
            shift_reg <= '0;
          end else if (serial_valid) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            if (load_ok) begin
              dataout    <= shift_reg;
              out_valid  <= 1'b1;
              parity_err <= (^shift_reg) ^ serial_in;
            end else begin
              overrun    <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule
